// File: rtl/aidc_lite_pkg.sv
// Shared AIDC-Lite block geometry, lane state encoding and header field layout.
// Pure declarations: no latency and no flow control.
package aidc_lite_pkg;

    localparam int BLK_BYTES      = 128;
    localparam int BEAT_BYTES     = 8;
    localparam int LANE_BUF_DEPTH = 8;

    localparam int BASE_LSB = 32;
    localparam int MASK_LSB = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HDR     = 2'd2,
        DONE    = 2'd3
    } lane_state_e;

endpackage

// File: rtl/aidc_lite_bdi_word_cls.sv
// Classifies one 32-bit word against the block base as zero-fit, base-fit or neither.
// Purely combinational with no flow control; a word that fits neither way yields a zero delta.
module aidc_lite_bdi_word_cls (
    input  logic [31:0] word_i,
    input  logic [31:0] base_i,
    output logic        zero_fit_o,
    output logic        base_fit_o,
    output logic [7:0]  delta_o
);

    logic [31:0] diff;

    always_comb begin
        diff       = word_i - base_i;
        zero_fit_o = (&word_i[31:7]) | ~(|word_i[31:7]);
        base_fit_o = (&diff[31:7]) | ~(|diff[31:7]);
        if (zero_fit_o) begin
            delta_o = word_i[7:0];
        end else if (base_fit_o) begin
            delta_o = diff[7:0];
        end else begin
            delta_o = 8'd0;
        end
    end

endmodule

// File: rtl/aidc_lite_comp_bdi.sv
// BDI lane: 128B block -> {base, mask} header plus signed 8-bit deltas; eop -> done_o in 3 cycles.
// No backpressure: every valid beat is consumed, and lane-buffer writes are fire-and-forget.
module aidc_lite_comp_bdi
    import aidc_lite_pkg::*;
#(
    parameter int BEATS   = 16,
    parameter int DELTA_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        sop_i,
    input  logic        eop_i,
    input  logic [63:0] data_i,
    output logic        valid_o,
    output logic [2:0]  addr_o,
    output logic [63:0] data_o,
    output logic        done_o,
    output logic        fail_o
);

    localparam int CNT_W  = $clog2(BEATS) + 1;
    localparam int MASK_W = 2 * BEATS;
    localparam int ADDR_W = $clog2(LANE_BUF_DEPTH);

    if (DELTA_W != 8) begin : g_bad_delta_w
        $error("aidc_lite_comp_bdi: DELTA_W must be 8");
    end
    if (BEATS != 4 && BEATS != 8 && BEATS != 16) begin : g_bad_beats
        $error("aidc_lite_comp_bdi: BEATS must be 4, 8 or 16");
    end
    if (BEATS * BEAT_BYTES > BLK_BYTES) begin : g_bad_blk
        $error("aidc_lite_comp_bdi: block larger than BLK_BYTES");
    end

    lane_state_e        state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        base_q;
    logic [MASK_W-1:0]  mask_q;
    logic               fail_q;
    logic [63:0]        asm_q;
    logic               valid_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [63:0]        data_q;
    logic               done_q;
    logic               fail_out_q;

    logic               beat_acc;
    logic               in_range;
    logic               grp_wr;
    logic [CNT_W-1:0]   k;
    logic [CNT_W-1:0]   cnt_d;
    logic [31:0]        base_d;
    logic [MASK_W-1:0]  mask_d;
    logic               fail_d;
    logic [63:0]        asm_d;
    logic [ADDR_W-1:0]  grp_addr;
    logic [63:0]        hdr;

    logic               zf0, bf0, zf1, bf1;
    logic [7:0]         dl0, dl1;

    // The sop beat classifies against its own word 0, before base_q is loaded.
    assign base_d = sop_i ? data_i[31:0] : base_q;

    aidc_lite_bdi_word_cls u_cls_lo (
        .word_i     (data_i[31:0]),
        .base_i     (base_d),
        .zero_fit_o (zf0),
        .base_fit_o (bf0),
        .delta_o    (dl0)
    );

    aidc_lite_bdi_word_cls u_cls_hi (
        .word_i     (data_i[63:32]),
        .base_i     (base_d),
        .zero_fit_o (zf1),
        .base_fit_o (bf1),
        .delta_o    (dl1)
    );

    always_comb begin
        beat_acc = valid_i && (sop_i || state_q == COLLECT) && (state_q != HDR);
        k        = sop_i ? '0 : cnt_q;
        in_range = (k < CNT_W'(BEATS));
        mask_d   = sop_i ? '0 : mask_q;
        fail_d   = sop_i ? 1'b0 : fail_q;
        asm_d    = asm_q;
        cnt_d    = k;
        grp_wr   = 1'b0;
        grp_addr = ADDR_W'(k >> 2) + ADDR_W'(1);

        if (in_range) begin
            if (k[1:0] == 2'd0) begin
                asm_d = '0;
            end
            asm_d[16*k[1:0] +: 16] = {dl1, dl0};
            mask_d[2*k +: 2]       = {zf1, zf0};
            fail_d = fail_d | (!zf0 && !bf0) | (!zf1 && !bf1);
            cnt_d  = k + CNT_W'(1);
            grp_wr = (k[1:0] == 2'd3) || eop_i;
        end else begin
            // Beats past the block length are dropped; count saturates at BEATS.
            fail_d = 1'b1;
        end

        if (eop_i && (k != CNT_W'(BEATS - 1))) begin
            fail_d = 1'b1;
        end

        hdr = '0;
        hdr[BASE_LSB +: 32]     = base_q;
        hdr[MASK_LSB +: MASK_W] = mask_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            mask_q     <= '0;
            fail_q     <= 1'b0;
            asm_q      <= '0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            fail_out_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (beat_acc) begin
                base_q     <= base_d;
                mask_q     <= mask_d;
                fail_q     <= fail_d;
                asm_q      <= asm_d;
                cnt_q      <= cnt_d;
                done_q     <= 1'b0;
                fail_out_q <= 1'b0;
                if (grp_wr) begin
                    valid_q <= 1'b1;
                    addr_q  <= grp_addr;
                    data_q  <= asm_d;
                end
                state_q <= eop_i ? HDR : COLLECT;
            end else begin
                case (state_q)
                    HDR: begin
                        valid_q <= 1'b1;
                        addr_q  <= '0;
                        data_q  <= hdr;
                        state_q <= DONE;
                    end
                    DONE: begin
                        done_q     <= 1'b1;
                        fail_out_q <= fail_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign done_o  = done_q;
    assign fail_o  = fail_out_q;

endmodule

// File: tb/tb_aidc_lite_comp_bdi.sv
// Scoreboard bench for the BDI lane: expected lane-buffer writes are queued as beats are driven.
module tb_aidc_lite_comp_bdi;

    localparam int BEATS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        sop_i;
    logic        eop_i;
    logic [63:0] data_i;
    logic        valid_o;
    logic [2:0]  addr_o;
    logic [63:0] data_o;
    logic        done_o;
    logic        fail_o;

    aidc_lite_comp_bdi #(.BEATS(BEATS), .DELTA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .sop_i   (sop_i),
        .eop_i   (eop_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .addr_o  (addr_o),
        .data_o  (data_o),
        .done_o  (done_o),
        .fail_o  (fail_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  addr;
        logic [63:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_errors = 0;
    wr_t         sb[$];
    logic        exp_fail;
    logic [31:0] words [0:39];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic fits8(input logic [31:0] v);
        return ($signed(v) >= -128) && ($signed(v) <= 127);
    endfunction

    // Write monitor: every lane-buffer write must match the oldest queued expectation.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("wr_unexpected", {63'd0, valid_o}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", {61'd0, addr_o}, {61'd0, e.addr});
                    chk("wr_data", data_o, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic send_block(input int nb, input bit with_eop, input bit was_done);
        logic [31:0] base;
        logic [31:0] mask;
        logic [63:0] asmv;
        logic [31:0] w;
        logic [31:0] d;
        logic        f;
        bit          last;
        int          idx;
        wr_t         e;
        base = words[0];
        mask = '0;
        asmv = '0;
        f    = 1'b0;
        for (int k = 0; k < nb; k++) begin
            last    = with_eop && (k == nb - 1);
            valid_i = 1'b1;
            sop_i   = (k == 0);
            eop_i   = last;
            data_i  = {words[2*k+1], words[2*k]};
            if (k < BEATS) begin
                if (k % 4 == 0) asmv = '0;
                for (int j = 0; j < 2; j++) begin
                    idx = 2*k + j;
                    w   = words[idx];
                    d   = w - base;
                    if (fits8(w)) begin
                        mask[idx] = 1'b1;
                        asmv[8*(idx%8) +: 8] = w[7:0];
                    end else if (fits8(d)) begin
                        asmv[8*(idx%8) +: 8] = d[7:0];
                    end else begin
                        f = 1'b1;
                    end
                end
                if ((k % 4 == 3) || last) begin
                    e.addr = 3'(1 + k/4);
                    e.data = asmv;
                    sb.push_back(e);
                end
            end else begin
                f = 1'b1;
            end
            if (last && k != BEATS - 1) f = 1'b1;
            @(posedge clk); #1;
            if (k == 0 && was_done) chk("done_drop", {63'd0, done_o}, 64'd0);
        end
        valid_i = 1'b0;
        sop_i   = 1'b0;
        eop_i   = 1'b0;
        if (with_eop) begin
            e.addr = 3'd0;
            e.data = {base, mask};
            sb.push_back(e);
            exp_fail = f;
        end
    endtask

    // Entered one cycle after the eop beat; strict mode pins done_o to eop + 3.
    task automatic check_done(input bit strict);
        int n;
        if (strict) begin
            chk("done_t1", {63'd0, done_o}, 64'd0);
            @(posedge clk); #1;
            chk("done_t2", {63'd0, done_o}, 64'd0);
            @(posedge clk); #1;
        end else begin
            n = 0;
            while (done_o !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("done", {63'd0, done_o}, 64'd1);
        chk("fail", {63'd0, fail_o}, {63'd0, exp_fail});
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic fill_const(input logic [31:0] v);
        for (int i = 0; i < 40; i++) words[i] = v;
    endtask

    task automatic fill_incr();
        for (int i = 0; i < 40; i++) words[i] = 32'h1000_0000 + 32'(i);
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        sop_i   = 1'b0;
        eop_i   = 1'b0;
        data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_addr",  {61'd0, addr_o},  64'd0);
        chk("rst_data",  data_o,           64'd0);
        chk("rst_done",  {63'd0, done_o},  64'd0);
        chk("rst_fail",  {63'd0, fail_o},  64'd0);

        // valid without sop in IDLE must be ignored
        valid_i = 1'b1;
        data_i  = 64'h1234_5678_9ABC_DEF0;
        repeat (2) @(posedge clk);
        #1;
        valid_i = 1'b0;

        fill_const(32'h0);
        send_block(16, 1'b1, 1'b0);
        check_done(1'b1);

        fill_incr();
        send_block(16, 1'b1, 1'b1);
        check_done(1'b1);

        fill_incr();
        words[17] = 32'h1000_0100;
        send_block(16, 1'b1, 1'b1);
        check_done(1'b1);

        for (int i = 0; i < 40; i++) words[i] = (i % 2 == 1) ? 32'hFFFF_FF80 : 32'h8000_007F;
        words[0] = 32'h8000_0000;
        send_block(16, 1'b1, 1'b1);
        check_done(1'b1);

        fill_incr();
        send_block(10, 1'b1, 1'b1);
        check_done(1'b1);

        for (int i = 0; i < 40; i++) words[i] = $urandom;
        send_block(6, 1'b0, 1'b1);
        fill_const(32'h0);
        send_block(16, 1'b1, 1'b0);
        check_done(1'b1);

        fill_const(32'h0000_0005);
        send_block(18, 1'b1, 1'b1);
        check_done(1'b0);

        fill_const(32'hFFFF_FFF0);
        words[1] = 32'h0000_0040;
        send_block(1, 1'b1, 1'b1);
        check_done(1'b1);

        fill_incr();
        send_block(5, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", {63'd0, valid_o}, 64'd0);
        chk("mid_rst_addr",  {61'd0, addr_o},  64'd0);
        chk("mid_rst_data",  data_o,           64'd0);
        chk("mid_rst_done",  {63'd0, done_o},  64'd0);
        chk("mid_rst_fail",  {63'd0, fail_o},  64'd0);
        rst     = 1'b0;
        valid_i = 1'b1;
        data_i  = {words[11], words[10]};
        repeat (4) @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_done", {63'd0, done_o}, 64'd0);
        chk("post_rst_sb",   64'(sb.size()),  64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
